// File: rtl/tx_arb_pkg.sv
// Shared types and constants for the byte-serialising transmit arbiter.
package tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GUARD = 2'd2
  } state_e;

  localparam logic [7:0] HDR_BASE = 8'hA0;
  localparam int         ID_W     = 4;

  function automatic logic [7:0] header_byte(input logic [ID_W-1:0] id);
    return HDR_BASE | {{(8-ID_W){1'b0}}, id};
  endfunction

endpackage

// File: rtl/tx_arbiter_rr_pick.sv
// Round-robin selector: first asserted request at or after ptr_in, wrapping.
module rr_pick
  import tx_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_in,
  input  logic [ID_W-1:0]    ptr_in,
  output logic [ID_W-1:0]    grant_out,
  output logic               any_out
);

  logic [2*NUM_REQ-1:0] rotated;

  // Rotate so bit i means "requester ptr+i"; scanning high-to-low leaves the
  // lowest offset as the final winner.
  always_comb begin
    rotated   = {req_in, req_in} >> ptr_in;
    grant_out = '0;
    any_out   = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        any_out   = 1'b1;
        grant_out = ID_W'((int'(ptr_in) + i) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin arbiter that frames one requester word into header + LSB-first
// bytes and feeds them one at a time to a downstream byte serializer.
//   state | meaning
//   IDLE  | arbitrating; ready offered to the selected requester
//   ISSUE | waiting for tx not busy, then strobing the current byte
//   GUARD | one cycle covering the tx busy-assert latency
module tx_arbiter
  import tx_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int WORD_BYTES = 4
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic [NUM_REQ-1:0]                   req_valid_in,
  input  logic [NUM_REQ-1:0][WORD_BYTES*8-1:0] req_data_in,
  output logic [NUM_REQ-1:0]                   req_ready_out,
  input  logic                                 tx_busy_in,
  output logic                                 tx_new_data_out,
  output logic [7:0]                           tx_data_out,
  output logic                                 busy_out,
  output logic [ID_W-1:0]                      grant_id_out
);

  localparam int W    = WORD_BYTES * 8;
  localparam int BI_W = 4;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [BI_W-1:0]   byte_idx_q, byte_idx_d;
  logic [W-1:0]      shift_q, shift_d;
  logic              tx_new_q, tx_new_d;
  logic [7:0]        tx_data_q, tx_data_d;

  logic [ID_W-1:0]   pick;
  logic              any_valid;
  logic [W-1:0]      pick_word;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req_in    (req_valid_in),
    .ptr_in    (rr_ptr_q),
    .grant_out (pick),
    .any_out   (any_valid)
  );

  always_comb begin
    pick_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == ID_W'(i)) pick_word = req_data_in[i];
    end
  end

  assign req_ready_out = (!rst_in && state_q == IDLE && any_valid)
                         ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << pick) : '0;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    tx_new_d   = 1'b0;
    tx_data_d  = tx_data_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          shift_d    = pick_word;
          grant_d    = pick;
          rr_ptr_d   = (pick == ID_W'(NUM_REQ - 1)) ? '0 : pick + ID_W'(1);
          byte_idx_d = '0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (!tx_busy_in) begin
          tx_new_d = 1'b1;
          // Byte 0 is the header; payload bytes are consumed from the LSB end.
          if (byte_idx_q == '0) begin
            tx_data_d = header_byte(grant_q);
          end else begin
            tx_data_d = shift_q[7:0];
            shift_d   = shift_q >> 8;
          end
          state_d = GUARD;
        end
      end
      GUARD: begin
        if (byte_idx_q == BI_W'(WORD_BYTES)) begin
          state_d = IDLE;
        end else begin
          byte_idx_d = byte_idx_q + BI_W'(1);
          state_d    = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      tx_new_q   <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      tx_new_q   <= tx_new_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx_new_data_out = tx_new_q;
  assign tx_data_out     = tx_data_q;
  assign busy_out        = (state_q != IDLE);
  assign grant_id_out    = grant_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Self-checking bench for tx_arbiter with a behavioural byte-serializer model.
module tb_tx_arbiter;

  localparam int NR = 4;
  localparam int WB = 2;

  logic                       clk = 1'b0;
  logic                       rst_in = 1'b1;
  logic [NR-1:0]              req_valid_in = '0;
  logic [NR-1:0][WB*8-1:0]    req_data_in = '0;
  logic [NR-1:0]              req_ready_out;
  logic                       tx_busy_in;
  logic                       tx_new_data_out;
  logic [7:0]                 tx_data_out;
  logic                       busy_out;
  logic [3:0]                 grant_id_out;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  int            m_ptr = 0;
  int            m_grant = 0;
  bit            m_busy = 0;
  int            exp_q[$];
  int            strobes[$];
  int            grants[$];
  logic [7:0]    last_data = 8'h00;
  int            last_strb = -10;
  bit            prev_busy = 0;
  bit            busy_seen = 0;
  int            hs_cyc = 0;
  int            frame_strb = 0;
  logic [NR-1:0] last_ready = '0;
  logic [NR-1:0] exp_rdy;
  int            mon_g;
  int            mon_b;
  bit            strb_seen = 0;
  int            tx_cnt = 0;
  bit            force_busy = 0;
  bit            reassert[NR];
  int            ready_cnt[NR];

  assign tx_busy_in = force_busy | (tx_cnt != 0);

  tx_arbiter #(.NUM_REQ(NR), .WORD_BYTES(WB)) dut (
    .clk_in          (clk),
    .rst_in          (rst_in),
    .req_valid_in    (req_valid_in),
    .req_data_in     (req_data_in),
    .req_ready_out   (req_ready_out),
    .tx_busy_in      (tx_busy_in),
    .tx_new_data_out (tx_new_data_out),
    .tx_data_out     (tx_data_out),
    .busy_out        (busy_out),
    .grant_id_out    (grant_id_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int model_pick(input logic [NR-1:0] v, input int ptr);
    for (int k = 0; k < NR; k++) begin
      if (v[(ptr + k) % NR]) return (ptr + k) % NR;
    end
    return -1;
  endfunction

  // Reference model: predicts ready, grant order, busy and the exact byte stream.
  always @(negedge clk) begin
    cyc++;
    strb_seen = tx_new_data_out;
    if (rst_in) begin
      chk("rst_ready", req_ready_out, '0);
      m_ptr = 0; m_grant = 0; m_busy = 0;
      exp_q.delete();
      last_data = 8'h00; last_strb = -10; prev_busy = 0;
      last_ready = '0; frame_strb = 0;
    end else begin
      chk("busy_out", busy_out, m_busy);
      chk("grant_id", grant_id_out, m_grant);
      exp_rdy = '0;
      mon_g = -1;
      if (!m_busy) begin
        mon_g = model_pick(req_valid_in, m_ptr);
        if (mon_g >= 0) exp_rdy[mon_g] = 1'b1;
      end
      chk("ready", req_ready_out, exp_rdy);
      if (tx_new_data_out) begin
        strobes.push_back(tx_data_out);
        frame_strb++;
        chk("strobe_gap_ok", (cyc - last_strb) >= 2, 1);
        chk("strobe_while_busy", prev_busy, 0);
        if (exp_q.size() == 0) begin
          chk("extra_strobe", 1, 0);
          last_data = tx_data_out;
        end else begin
          mon_b = exp_q.pop_front();
          chk("byte", tx_data_out, mon_b);
          if (frame_strb == 1 && !busy_seen) chk("first_latency", cyc - hs_cyc, 2);
          if (exp_q.size() == 0) m_busy = 0;
          last_data = mon_b[7:0];
        end
        last_strb = cyc;
      end else begin
        chk("data_hold", tx_data_out, last_data);
      end
      if (mon_g >= 0) begin
        m_grant = mon_g;
        m_ptr = (mon_g + 1) % NR;
        m_busy = 1;
        exp_q.push_back(8'hA0 | mon_g);
        for (int b = 0; b < WB; b++) exp_q.push_back((req_data_in[mon_g] >> (8 * b)) & 8'hFF);
        grants.push_back(mon_g);
        hs_cyc = cyc;
        busy_seen = 0;
        frame_strb = 0;
      end else if (m_busy && tx_busy_in) begin
        busy_seen = 1;
      end
      prev_busy = tx_busy_in;
      last_ready = req_ready_out;
    end
  end

  // One cycle: serializer model (20 cycles busy, asserted the cycle after a
  // strobe) and requesters that drop or renew their word after a handshake.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rst_in) tx_cnt = 0;
    else if (strb_seen) tx_cnt = 20;
    else if (tx_cnt > 0) tx_cnt--;
    for (int g = 0; g < NR; g++) begin
      if (last_ready[g]) begin
        ready_cnt[g]++;
        if (reassert[g]) req_data_in[g] = 16'($urandom);
        else req_valid_in[g] = 1'b0;
      end
    end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while ((req_valid_in != '0 || busy_out || tx_cnt != 0) && n < 3000) begin
      tick();
      n++;
    end
    chk({tag, "_timeout_ok"}, n < 3000, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, req_ready_out, '0);
    chk({tag, "_new"}, tx_new_data_out, 0);
    chk({tag, "_data"}, tx_data_out, 8'h00);
    chk({tag, "_grant"}, grant_id_out, 0);
    chk({tag, "_busy"}, busy_out, 0);
  endtask

  initial begin
    int n;
    int n0;
    int fcnt;
    logic [7:0] exp_bytes[$];
    for (int g = 0; g < NR; g++) begin
      reassert[g] = 0;
      ready_cnt[g] = 0;
    end

    req_valid_in = 4'b0101;
    tick(); tick();
    chk_reset_outputs("reset");
    req_valid_in = '0;
    rst_in = 1'b0;
    tick();

    // All four requesters at once: strict order from pointer 0.
    grants.delete(); strobes.delete();
    for (int i = 0; i < NR; i++) req_data_in[i] = {4'h0, 4'(i), 4'h0, 4'(i)};
    req_valid_in = '1;
    wait_done("all4");
    chk("all4_grants", grants.size(), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++) chk("all4_order", grants[i], i);
    chk("all4_strobes", strobes.size(), 12);
    for (int i = 0; i < 4 && 3 * i + 2 < strobes.size(); i++) begin
      chk("all4_hdr", strobes[3 * i], 8'hA0 + i);
      chk("all4_lo", strobes[3 * i + 1], i);
      chk("all4_hi", strobes[3 * i + 2], i);
    end

    // Fairness: 0 and 2 keep requesting.
    grants.delete();
    reassert[0] = 1; reassert[2] = 1;
    req_data_in[0] = 16'h1111; req_data_in[2] = 16'h2222;
    req_valid_in = 4'b0101;
    n = 0;
    while (grants.size() < 4 && n < 2000) begin tick(); n++; end
    chk("fair_timeout_ok", n < 2000, 1);
    reassert[0] = 0; reassert[2] = 0;
    wait_done("fair");
    for (int i = 0; i < 4 && i < grants.size(); i++) chk("fair_order", grants[i], (i % 2) * 2);

    // Single request with a known word.
    grants.delete(); strobes.delete();
    n0 = ready_cnt[1];
    req_data_in[1] = 16'hBEEF;
    req_valid_in[1] = 1'b1;
    wait_done("single");
    chk("single_ready_pulses", ready_cnt[1] - n0, 1);
    chk("single_grants", grants.size(), 1);
    if (grants.size() > 0) chk("single_grant", grants[0], 1);
    exp_bytes = '{8'hA1, 8'hEF, 8'hBE};
    chk("single_strobes", strobes.size(), 3);
    for (int i = 0; i < 3 && i < strobes.size(); i++) chk("single_byte", strobes[i], exp_bytes[i]);
    chk("single_busy_low", busy_out, 0);

    // Backpressure for 50 cycles right after the handshake.
    strobes.delete();
    req_data_in[3] = 16'h1234;
    req_valid_in[3] = 1'b1;
    n = 0;
    while (!busy_out && n < 100) begin tick(); n++; end
    chk("bp_start_ok", n < 100, 1);
    force_busy = 1;
    n0 = strobes.size();
    repeat (50) tick();
    chk("bp_no_strobe", strobes.size(), n0);
    force_busy = 0;
    wait_done("bp");
    exp_bytes = '{8'hA3, 8'h34, 8'h12};
    chk("bp_strobes", strobes.size(), 3);
    for (int i = 0; i < 3 && i < strobes.size(); i++) chk("bp_byte", strobes[i], exp_bytes[i]);

    // Reset after the second strobe of a frame from requester 1.
    req_data_in[1] = 16'hCAFE;
    req_valid_in[1] = 1'b1;
    n = 0;
    while (!busy_out && n < 100) begin tick(); n++; end
    while (frame_strb < 2 && n < 300) begin tick(); n++; end
    chk("midrst_reach_ok", n < 300, 1);
    rst_in = 1'b1;
    tick();
    chk_reset_outputs("midrst");
    rst_in = 1'b0;
    grants.delete();
    req_data_in[1] = 16'h5A5A; req_data_in[3] = 16'hC3C3;
    req_valid_in = 4'b1010;
    wait_done("postrst");
    chk("postrst_grants", grants.size(), 2);
    if (grants.size() >= 2) begin
      chk("postrst_first", grants[0], 1);
      chk("postrst_second", grants[1], 3);
    end

    // Randomised traffic, data churn, valid drops and backpressure bursts.
    fcnt = 0;
    for (int t = 0; t < 3000; t++) begin
      tick();
      for (int g = 0; g < NR; g++) begin
        if (!req_valid_in[g]) begin
          req_data_in[g] = 16'($urandom);
          if ($urandom_range(0, 3) == 0) req_valid_in[g] = 1'b1;
        end else if ($urandom_range(0, 59) == 0) begin
          req_valid_in[g] = 1'b0;
        end
      end
      if (!force_busy && $urandom_range(0, 99) == 0) begin
        force_busy = 1;
        fcnt = $urandom_range(5, 40);
      end else if (force_busy) begin
        if (fcnt == 0) force_busy = 0;
        else fcnt--;
      end
    end
    force_busy = 0;
    wait_done("random");
    chk("random_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
